// File: rtl/rf_write_ctrl_if.sv
// rf_write_ctrl_if: writeback requesters and register-file write port bundle
interface rf_write_ctrl_if #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_w;
    logic [AW-1:0]        rf_rd;
    logic [XLEN-1:0]      rf_wdata;
    logic                 init_done;
    modport master (
        output hold, req_valid, req_rd, req_data,
        input  req_ready, rf_w, rf_rd, rf_wdata, init_done
    );
    modport slave (
        input  hold, req_valid, req_rd, req_data,
        output req_ready, rf_w, rf_rd, rf_wdata, init_done
    );
endinterface

// File: rtl/rf_write_ctrl.sv
// rf_write_ctrl: register-file clear sequencer and round-robin write-port arbiter
module rf_write_ctrl #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input logic clk,
    input logic reset,
    rf_write_ctrl_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [IW-1:0] rr_ptr, rr_n, gidx;
    logic          found;
    logic          w, w_n, done, done_n;
    logic [AW-1:0] rd, rd_n, g_rd;
    logic [XLEN-1:0] wd, wd_n, g_data;
    // Round-robin search upward from rr_ptr; nothing is granted while clearing or on hold
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[IW'((int'(rr_ptr) + k) % NREQ)]) begin
                found = 1'b1;
                gidx  = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
        if (state != RUN || bus.hold) found = 1'b0;
    end
    assign bus.req_ready = found ? NREQ'(1) << gidx : '0;
    assign g_rd          = bus.req_rd[int'(gidx)*AW +: AW];
    assign g_data        = bus.req_data[int'(gidx)*XLEN +: XLEN];
    // Next state: clear one register per cycle, then forward the granted request
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rr_n    = rr_ptr;
        w_n     = 1'b0;
        rd_n    = rd;
        wd_n    = wd;
        done_n  = done;
        if (state == CLEAR) begin
            w_n   = 1'b1;
            rd_n  = cnt;
            wd_n  = '0;
            cnt_n = cnt + 1'b1;
            if (cnt == '1) begin
                state_n = RUN;
                done_n  = 1'b1;
            end
        end else if (found) begin
            w_n  = g_rd != '0;
            rd_n = g_rd;
            wd_n = g_data;
            rr_n = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        end
    end
    // State and registered write-port outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR;
            cnt    <= '0;
            rr_ptr <= '0;
            w      <= 1'b0;
            rd     <= '0;
            wd     <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rr_ptr <= rr_n;
            w      <= w_n;
            rd     <= rd_n;
            wd     <= wd_n;
            done   <= done_n;
        end
    end
    assign bus.rf_w      = w;
    assign bus.rf_rd     = rd;
    assign bus.rf_wdata  = wd;
    assign bus.init_done = done;
endmodule

// File: tb/tb_rf_write_ctrl.sv
// tb_rf_write_ctrl: table vectors, corner sequences and random traffic against a reference model
module tb_rf_write_ctrl;
    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;
    always #5 clk = ~clk;
    rf_write_ctrl_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();
    rf_write_ctrl #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
    // reference model: clear progress, rr pointer, and expected registered outputs
    int              m_clr, m_ptr;
    logic            m_w, m_done;
    logic [AW-1:0]   m_rd;
    logic [XLEN-1:0] m_wd;
    logic [NREQ-1:0] got_ready;
    typedef struct {
        logic                 h;
        logic [NREQ-1:0]      v;
        logic [NREQ*AW-1:0]   rd;
        logic [NREQ*XLEN-1:0] d;
        logic [NREQ-1:0]      er;
        logic                 ew;
        logic [AW-1:0]        erd;
        logic [XLEN-1:0]      ewd;
    } vec_t;
    vec_t tbl[12];
    function automatic void check(string n, logic [31:0] a, logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endfunction
    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] g = '0;
        if (m_clr < 32 || bus.hold) return g;
        for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (bus.req_valid[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction
    function automatic void model_step(logic r, logic [NREQ-1:0] g);
        if (r) begin
            m_clr = 0; m_ptr = 0; m_w = 0; m_rd = '0; m_wd = '0; m_done = 0;
        end else if (m_clr < 32) begin
            m_w = 1; m_rd = AW'(m_clr); m_wd = '0; m_clr++;
            m_done = (m_clr == 32);
        end else if (g != '0) begin
            for (int i = 0; i < NREQ; i++) if (g[i]) begin
                m_rd  = bus.req_rd[i*AW +: AW];
                m_wd  = bus.req_data[i*XLEN +: XLEN];
                m_w   = (m_rd != 0);
                m_ptr = (i + 1) % NREQ;
            end
        end else m_w = 0;
    endfunction
    task automatic apply(input logic r, input logic h, input logic [NREQ-1:0] v,
                         input logic [NREQ*AW-1:0] rd, input logic [NREQ*XLEN-1:0] d);
        logic [NREQ-1:0] er;
        reset = r;
        bus.hold = h;
        bus.req_valid = v;
        bus.req_rd = rd;
        bus.req_data = d;
        #3;
        er = model_ready();
        got_ready = bus.req_ready;
        if (!r) check("req_ready", 32'(got_ready), 32'(er));
        @(posedge clk);
        model_step(r, er);
        #1;
        check("rf_w", 32'(bus.rf_w), 32'(m_w));
        check("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
        check("rf_wdata", bus.rf_wdata, m_wd);
        check("init_done", 32'(bus.init_done), 32'(m_done));
    endtask
    localparam logic [NREQ*AW-1:0]   RD_ALL = {5'd3, 5'd2, 5'd1};
    localparam logic [NREQ*XLEN-1:0] D_ALL  = {32'hC, 32'hB, 32'hA};
    initial begin
        tbl[0]  = '{0, 3'b001, {5'd0, 5'd0, 5'd5}, {64'h0, 32'hDEADBEEF}, 3'b001, 1, 5'd5, 32'hDEADBEEF};
        tbl[1]  = '{0, 3'b000, '0, '0, 3'b000, 0, 5'd5, 32'hDEADBEEF};
        tbl[2]  = '{0, 3'b111, RD_ALL, D_ALL, 3'b010, 1, 5'd2, 32'hB};
        tbl[3]  = '{0, 3'b111, RD_ALL, D_ALL, 3'b100, 1, 5'd3, 32'hC};
        tbl[4]  = '{0, 3'b111, RD_ALL, D_ALL, 3'b001, 1, 5'd1, 32'hA};
        tbl[5]  = '{0, 3'b111, RD_ALL, D_ALL, 3'b010, 1, 5'd2, 32'hB};
        tbl[6]  = '{1, 3'b111, RD_ALL, D_ALL, 3'b000, 0, 5'd2, 32'hB};
        tbl[7]  = '{1, 3'b111, RD_ALL, D_ALL, 3'b000, 0, 5'd2, 32'hB};
        tbl[8]  = '{1, 3'b111, RD_ALL, D_ALL, 3'b000, 0, 5'd2, 32'hB};
        tbl[9]  = '{0, 3'b111, RD_ALL, D_ALL, 3'b100, 1, 5'd3, 32'hC};
        tbl[10] = '{0, 3'b010, '0, {32'h0, 32'h1234, 32'h0}, 3'b010, 0, 5'd0, 32'h1234};
        tbl[11] = '{0, 3'b111, RD_ALL, D_ALL, 3'b100, 1, 5'd3, 32'hC};
        m_clr = 0; m_ptr = 0; m_w = 0; m_rd = '0; m_wd = '0; m_done = 0;
        @(posedge clk);
        #1;
        apply(1, 0, '0, '0, '0);
        apply(1, 0, '0, '0, '0);
        check("reset rf_w", 32'(bus.rf_w), 0);
        check("reset init_done", 32'(bus.init_done), 0);
        for (int i = 0; i < 32; i++) begin
            apply(0, 0, 3'b111, RD_ALL, D_ALL);
            check("clear ready", 32'(got_ready), 0);
            check("clear rf_w", 32'(bus.rf_w), 1);
            check("clear rf_rd", 32'(bus.rf_rd), 32'(i));
            check("clear rf_wdata", bus.rf_wdata, 0);
        end
        check("clear done", 32'(bus.init_done), 1);
        apply(0, 0, '0, '0, '0);
        check("idle rf_w", 32'(bus.rf_w), 0);
        for (int i = 0; i < 12; i++) begin
            apply(0, tbl[i].h, tbl[i].v, tbl[i].rd, tbl[i].d);
            check($sformatf("tbl%0d ready", i), 32'(got_ready), 32'(tbl[i].er));
            check($sformatf("tbl%0d rf_w", i), 32'(bus.rf_w), 32'(tbl[i].ew));
            check($sformatf("tbl%0d rf_rd", i), 32'(bus.rf_rd), 32'(tbl[i].erd));
            check($sformatf("tbl%0d rf_wdata", i), bus.rf_wdata, tbl[i].ewd);
        end
        apply(0, 0, 3'b001, RD_ALL, D_ALL);
        check("pre-reset rf_w", 32'(bus.rf_w), 1);
        apply(1, 0, '0, '0, '0);
        check("midreset rf_w", 32'(bus.rf_w), 0);
        check("midreset init_done", 32'(bus.init_done), 0);
        apply(0, 0, '0, '0, '0);
        check("restart rf_rd", 32'(bus.rf_rd), 0);
        check("restart rf_w", 32'(bus.rf_w), 1);
        for (int n = 0; n < 1500; n++) begin
            logic [NREQ*AW-1:0]   rd;
            logic [NREQ*XLEN-1:0] d;
            for (int i = 0; i < NREQ; i++) begin
                rd[i*AW +: AW]     = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
                d[i*XLEN +: XLEN]  = $urandom;
            end
            apply($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                  NREQ'($urandom), rd, d);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/rf_write_ctrl.md
# rf_write_ctrl

Write-port controller for the 32x32 register file. After reset it sequences a hardware clear of all 32 registers, one per cycle. It then round-robin arbitrates the single register-file write port among NREQ writeback requesters using a valid/ready handshake, and drives the file's write enable, destination and data from registered outputs. It sits between the multi-cycle core's writeback sources (ALU, load unit, CSR/other) and the register file's write port.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width (32 registers)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clock clk
- hold  input  1  when high, no new grants (all req_ready low)
- req_valid  input  NREQ  per-requester write request
- req_rd  input  NREQ*AW  destination per requester, requester i at bits [i*AW +: AW]
- req_data  input  NREQ*XLEN  write data per requester, requester i at [i*XLEN +: XLEN]
- req_ready  output  NREQ  grant, one-hot or zero, combinational
- rf_w  output  1  register-file write enable (registered)
- rf_rd  output  AW  register-file write address (registered)
- rf_wdata  output  XLEN  register-file write data (registered)
- init_done  output  1  high once the clear sequence has completed (registered)

## Operation
- States: CLEAR, RUN. Reset forces CLEAR, clear counter cnt=0, rr_ptr=0, and rf_w=0, rf_rd=0, rf_wdata=0, init_done=0.
- CLEAR:
  - Each edge loads rf_w=1, rf_rd=cnt, rf_wdata=0, then cnt increments.
  - The edge that loads rf_rd=31 also moves the state to RUN and sets init_done=1.
  - req_ready is held at all zeros throughout CLEAR.
- RUN, arbitration:
  - req_ready is all zeros when hold=1.
  - Otherwise, grant the first requester with req_valid=1, searching from index rr_ptr upward with wrap-around.
  - req_ready[i]=1 for that requester only.
- Handshake: req_valid[i] & req_ready[i] on an edge transfers the request.
  - rf_rd and rf_wdata load the granted req_rd/req_data.
  - rf_w loads 1 if the granted rd != 0, else 0. Writes to x0 are accepted but dropped.
  - rr_ptr loads (i+1) mod NREQ.
- No handshake in RUN: rf_w loads 0. rf_rd, rf_wdata and rr_ptr hold.
- A requester must hold valid, rd and data stable until ready. Dropping valid before grant is allowed; the request is then simply not taken.
- Reset mid-operation (CLEAR or RUN): any registered pending write is discarded (rf_w=0 next cycle) and the clear sequence restarts from 0.
- init_done stays 1 in RUN and returns to 0 only on reset.

## Timing
- Clear: 32 cycles. After reset deasserts, edges 1..32 present rf_rd=0..31 with rf_w=1. The register file commits each one on the following edge.
- req_ready can first be high in the cycle after edge 32.
- Grant latency: combinational in the cycle valid is seen, provided the requester is highest in rr order and hold=0.
- Write latency: handshake at edge N -> rf_w/rf_rd/rf_wdata valid during cycle N+1 -> register file commits at edge N+1.
- Throughput: one write per cycle.
- Fairness: with k continuously-valid requesters, each is granted at least once every k cycles.
- hold asserted in the same cycle as valid: no grant, no pointer change.

## Test plan
- Reset then idle: for 32 cycles, rf_w=1 with rf_rd stepping 0..31 and rf_wdata=0. After that, init_done=1 and rf_w=0. req_ready stays 0 during the clear.
- Single request: req0 valid, rd=5, data=0xDEADBEEF once in RUN -> req_ready=001 that cycle; next cycle rf_w=1, rf_rd=5, rf_wdata=0xDEADBEEF; the cycle after, rf_w=0.
- All three valid continuously (rd=1,2,3) -> grant order 0,1,2,0,1,2, one grant per cycle; rf_rd sequence 1,2,3,1,2,3.
- x0 write: req1 rd=0, data=0x1234 -> req_ready[1]=1, but rf_w=0 next cycle; rr_ptr still advances to 2.
- hold=1 with all requesters valid for 3 cycles -> req_ready=000 and rf_w=0. When hold drops, grants resume from the unchanged rr_ptr.
- Reset asserted during RUN one cycle after a handshake -> rf_w=0 on the following cycle, init_done=0, and the clear restarts at rf_rd=0.
